// File: rtl/mc_rd_req_ctrl.sv
// Read-request controller between address sources and the MIG app_* port.
// Buffers incoming read addresses, issues one read command per accepted
// address, and tags returned beats with the address of their burst, in order.
//
// Handshakes: a transfer happens on every cycle where valid and ready are both
// high (req_valid & mc_rd_rdy on the request side, app_en & app_rdy on the MIG
// side). Valid is never withdrawn and its payload never changes while waiting
// for ready. The return path has no ready: each beat is presented once.
module mc_rd_req_ctrl #(
    parameter int ADDR_W    = 31,
    parameter int DATA_W    = 128,
    parameter int REQ_DEPTH = 4,
    parameter int MAX_OUT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              mc_rd_rdy,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    input  logic              app_rd_data_end,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic [2:0]        outstanding,
    output logic [15:0]       rd_count,
    output logic              err_unexp,
    output logic [1:0]        fsm_state
);

    localparam int RP_W = $clog2(REQ_DEPTH);
    localparam int TP_W = $clog2(MAX_OUT);
    localparam logic [RP_W:0] REQ_FULL = (RP_W+1)'(REQ_DEPTH);
    localparam logic [2:0]    OUT_MAX  = 3'(MAX_OUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] req_mem [REQ_DEPTH];
    logic [RP_W-1:0]   req_wp, req_rp;
    logic [RP_W:0]     req_cnt, req_cnt_next;

    logic [ADDR_W-1:0] tag_mem [MAX_OUT];
    logic [TP_W-1:0]   tag_wp, tag_rp;
    logic [2:0]        out_next;

    logic req_push, issue, beat_ok, tag_pop;

    assign req_push  = req_valid & mc_rd_rdy;
    assign issue     = app_en & app_rdy;
    // A beat is only accepted when some burst is waiting for it.
    assign beat_ok   = app_rd_data_valid & (outstanding != 3'd0);
    assign tag_pop   = beat_ok & app_rd_data_end;
    assign app_cmd   = 3'b001;
    assign fsm_state = state;

    // Next occupancy of both FIFOs; simultaneous push and pop cancel out.
    always_comb begin
        req_cnt_next = req_cnt;
        if (req_push && !issue)
            req_cnt_next = req_cnt + 1'b1;
        else if (!req_push && issue)
            req_cnt_next = req_cnt - 1'b1;
        out_next = outstanding;
        if (issue && !tag_pop)
            out_next = outstanding + 3'd1;
        else if (!issue && tag_pop)
            out_next = outstanding - 3'd1;
    end

    // Next state is chosen from next-cycle occupancies so app_en is registered.
    always_comb begin
        state_next = state;
        app_en     = 1'b0;
        app_addr   = '0;
        case (state)
            ISSUE: begin
                app_en   = 1'b1;
                app_addr = req_mem[req_rp];
            end
            default: begin
                app_en = 1'b0;
            end
        endcase
        if (out_next == OUT_MAX)
            state_next = STALL;
        else if (req_cnt_next == '0)
            state_next = IDLE;
        else
            state_next = ISSUE;
    end

    // State, pointers, counters and the registered request-side ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_wp      <= '0;
            req_rp      <= '0;
            req_cnt     <= '0;
            tag_wp      <= '0;
            tag_rp      <= '0;
            outstanding <= '0;
            mc_rd_rdy   <= 1'b0;
            rd_count    <= '0;
            err_unexp   <= 1'b0;
        end else begin
            state       <= state_next;
            req_cnt     <= req_cnt_next;
            outstanding <= out_next;
            mc_rd_rdy   <= (req_cnt_next != REQ_FULL);
            if (req_push) req_wp <= req_wp + 1'b1;
            if (issue) begin
                req_rp <= req_rp + 1'b1;
                tag_wp <= tag_wp + 1'b1;
            end
            if (tag_pop) begin
                tag_rp   <= tag_rp + 1'b1;
                rd_count <= rd_count + 16'd1;
            end
            if (app_rd_data_valid && outstanding == 3'd0)
                err_unexp <= 1'b1;
        end
    end

    // FIFO storage; contents are meaningless once pointers are reset.
    always_ff @(posedge clk) begin
        if (req_push) req_mem[req_wp] <= req_addr;
        if (issue)    tag_mem[tag_wp] <= app_addr;
    end

    // Return path: one-cycle registered copy of each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_addr  <= '0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= beat_ok;
            if (beat_ok) begin
                rd_data <= app_rd_data;
                rd_addr <= tag_mem[tag_rp];
                rd_last <= app_rd_data_end;
            end
        end
    end

endmodule

// File: tb/tb_mc_rd_req_ctrl.sv
// Bench for mc_rd_req_ctrl: reset, basic issue/return, MIG backpressure,
// outstanding-limit stall, unexpected beats and reset mid-traffic.
module tb_mc_rd_req_ctrl;

    localparam int ADDR_W = 31;
    localparam int DATA_W = 128;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              mc_rd_rdy;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_rdy;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_valid;
    logic              app_rd_data_end;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic [2:0]        outstanding;
    logic [15:0]       rd_count;
    logic              err_unexp;
    logic [1:0]        fsm_state;

    mc_rd_req_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .mc_rd_rdy(mc_rd_rdy),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr), .rd_last(rd_last),
        .outstanding(outstanding), .rd_count(rd_count), .err_unexp(err_unexp),
        .fsm_state(fsm_state)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] ret_q[$];
    logic              mon_en = 1'b0;
    int                issued = 0;

    typedef struct {
        logic              v;
        logic              e;
        logic [DATA_W-1:0] d;
        logic              x_valid;
        logic [ADDR_W-1:0] x_addr;
        logic              x_last;
        logic [2:0]        x_out;
    } ret_vec_t;

    ret_vec_t tbl[6];

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic e, input logic [DATA_W-1:0] d);
        app_rd_data_valid = v;
        app_rd_data_end   = e;
        app_rd_data       = d;
    endtask

    // Scoreboard: command order on the MIG side and tag order on the return side
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_valid) begin
                if (ret_q.size() == 0) chk("ret_extra", 1, 0);
                else chk("ret_order", rd_addr, ret_q.pop_front());
            end
            if (app_en && app_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("issue_extra", 1, 0);
                end else begin
                    logic [ADDR_W-1:0] e;
                    e = exp_q.pop_front();
                    chk("issue_order", app_addr, e);
                    ret_q.push_back(e);
                end
                issued++;
            end
        end
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 128'hA1, 1'b1, 31'h20C0, 1'b0, 3'd2};
        tbl[1] = '{1'b1, 1'b1, 128'hA2, 1'b1, 31'h20C0, 1'b1, 3'd1};
        tbl[2] = '{1'b0, 1'b0, 128'h0,  1'b0, 31'h0,    1'b0, 3'd1};
        tbl[3] = '{1'b1, 1'b0, 128'hB1, 1'b1, 31'h20C8, 1'b0, 3'd1};
        tbl[4] = '{1'b1, 1'b1, 128'hB2, 1'b1, 31'h20C8, 1'b1, 3'd0};
        tbl[5] = '{1'b0, 1'b0, 128'h0,  1'b0, 31'h0,    1'b0, 3'd0};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; app_rdy = 1'b0;
        beat(1'b0, 1'b0, '0);

        // 1: reset
        repeat (3) tick();
        chk("rst_rdy", mc_rd_rdy, 0);
        chk("rst_app_en", app_en, 0);
        chk("rst_app_addr", app_addr, 0);
        chk("rst_out", outstanding, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_err", err_unexp, 0);
        chk("rst_state", fsm_state, 0);
        rst = 1'b0;
        tick();
        chk("rel_rdy", mc_rd_rdy, 1);
        chk("rel_app_en", app_en, 0);

        // 2: two requests, two 2-beat bursts back
        app_rdy = 1'b1;
        req_valid = 1'b1; req_addr = 31'h20C0;
        tick();
        chk("t2_en0", app_en, 1);
        chk("t2_addr0", app_addr, 31'h20C0);
        chk("t2_cmd", app_cmd, 3'b001);
        req_addr = 31'h20C8;
        tick();
        chk("t2_en1", app_en, 1);
        chk("t2_addr1", app_addr, 31'h20C8);
        chk("t2_out1", outstanding, 1);
        req_valid = 1'b0;
        tick();
        chk("t2_en_off", app_en, 0);
        chk("t2_out2", outstanding, 2);
        for (int i = 0; i < 6; i++) begin
            beat(tbl[i].v, tbl[i].e, tbl[i].d);
            tick();
            chk($sformatf("t2_vec%0d_valid", i), rd_valid, tbl[i].x_valid);
            chk($sformatf("t2_vec%0d_out", i), outstanding, tbl[i].x_out);
            if (tbl[i].x_valid) begin
                chk($sformatf("t2_vec%0d_addr", i), rd_addr, tbl[i].x_addr);
                chk($sformatf("t2_vec%0d_last", i), rd_last, tbl[i].x_last);
                chk($sformatf("t2_vec%0d_data", i), rd_data, tbl[i].d);
            end
        end
        chk("t2_count", rd_count, 2);
        chk("t2_err", err_unexp, 0);

        // 3: MIG stalls 5 cycles while 6 requests arrive
        begin
            int idx;
            logic acc;
            idx = 0;
            for (int k = 0; k < 6; k++) exp_q.push_back(31'h100 + 31'(k));
            mon_en = 1'b1;
            for (int c = 0; c < 40; c++) begin
                req_valid = (idx < 6);
                req_addr  = 31'h100 + 31'(idx);
                app_rdy   = (c >= 5);
                beat((c >= 5) && (outstanding != 3'd0), 1'b1, 128'(c));
                if (c == 1) chk("t3_hold1", app_addr, 31'h100);
                if (c == 4) begin
                    chk("t3_full_rdy", mc_rd_rdy, 0);
                    chk("t3_hold4_en", app_en, 1);
                    chk("t3_hold4_addr", app_addr, 31'h100);
                end
                acc = req_valid && mc_rd_rdy;
                tick();
                if (acc) idx++;
                if (idx == 6 && issued == 6 && outstanding == 3'd0) break;
            end
            req_valid = 1'b0;
            beat(1'b0, 1'b0, '0);
            tick();
            mon_en = 1'b0;
            chk("t3_issued", issued, 6);
            chk("t3_ret_left", ret_q.size(), 0);
            chk("t3_count", rd_count, 8);
        end

        // 4: outstanding limit, stall release and same-cycle issue + end
        begin
            int idx;
            logic acc;
            idx = 0;
            app_rdy = 1'b1;
            for (int c = 0; c < 12; c++) begin
                req_valid = (idx < 5);
                req_addr  = 31'(idx + 1);
                acc = req_valid && mc_rd_rdy;
                tick();
                if (acc) idx++;
            end
            req_valid = 1'b0;
            chk("t4_pushed", idx, 5);
            chk("t4_out4", outstanding, 4);
            chk("t4_state_stall", fsm_state, 2);
            chk("t4_en_off", app_en, 0);
            beat(1'b1, 1'b1, 128'hC1);
            tick();
            chk("t4_rel_en", app_en, 1);
            chk("t4_rel_addr", app_addr, 5);
            chk("t4_rel_out", outstanding, 3);
            chk("t4_rd_addr1", rd_addr, 1);
            chk("t4_rd_valid1", rd_valid, 1);
            beat(1'b1, 1'b1, 128'hC2);
            tick();
            chk("t4_same_out", outstanding, 3);
            chk("t4_rd_addr2", rd_addr, 2);
            chk("t4_idle", fsm_state, 0);
            chk("t4_en_done", app_en, 0);
            for (int k = 0; k < 3; k++) begin
                beat(1'b1, 1'b1, 128'(k));
                tick();
                chk($sformatf("t4_drain%0d_addr", k), rd_addr, 31'(3 + k));
                chk($sformatf("t4_drain%0d_last", k), rd_last, 1);
            end
            beat(1'b0, 1'b0, '0);
            tick();
            chk("t4_out0", outstanding, 0);
            chk("t4_count", rd_count, 13);
            chk("t4_err", err_unexp, 0);
        end

        // 5: beat with nothing outstanding
        beat(1'b1, 1'b1, 128'hDEAD);
        tick();
        beat(1'b0, 1'b0, '0);
        chk("t5_rd_valid", rd_valid, 0);
        chk("t5_err", err_unexp, 1);
        repeat (3) tick();
        chk("t5_err_sticky", err_unexp, 1);
        chk("t5_count", rd_count, 13);

        // 6: reset with 3 outstanding and 2 queued
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_err_clr", err_unexp, 0);
        begin
            int idx;
            logic acc;
            idx = 0;
            app_rdy = 1'b1;
            for (int c = 0; c < 20 && idx < 5; c++) begin
                req_valid = 1'b1;
                req_addr  = 31'h300 + 31'(idx);
                acc = req_valid && mc_rd_rdy;
                tick();
                if (acc) idx++;
                if (outstanding == 3'd3) app_rdy = 1'b0;
            end
            req_valid = 1'b0;
            chk("t6_pushed", idx, 5);
        end
        chk("t6_pre_out", outstanding, 3);
        chk("t6_pre_en", app_en, 1);
        rst = 1'b1;
        tick();
        chk("t6_rst_out", outstanding, 0);
        chk("t6_rst_rdy", mc_rd_rdy, 0);
        chk("t6_rst_en", app_en, 0);
        chk("t6_rst_count", rd_count, 0);
        rst = 1'b0;
        app_rdy = 1'b1;
        tick();
        chk("t6_rel_rdy", mc_rd_rdy, 1);
        chk("t6_rel_en", app_en, 0);
        beat(1'b1, 1'b0, 128'hE1);
        tick();
        chk("t6_late0_valid", rd_valid, 0);
        chk("t6_late0_err", err_unexp, 1);
        beat(1'b1, 1'b1, 128'hE2);
        tick();
        beat(1'b0, 1'b0, '0);
        chk("t6_late1_valid", rd_valid, 0);
        chk("t6_late1_out", outstanding, 0);
        tick();
        chk("t6_late_none", rd_valid, 0);
        chk("t6_err_held", err_unexp, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
